// File: rtl/pio_gen2_if.sv
// Avalon-MM slave bus bundle for pio_gen2: word address, select, write strobe
// and 32-bit data in each direction.
interface pio_gen2_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/pio_gen2.sv
// WIDTH-bit general-purpose I/O port for HPS software: direction control, atomic
// set/clear, synchronised inputs, sticky edge capture and a maskable interrupt.
module pio_gen2 #(
    parameter int unsigned     WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned     SYNC_STAGES = 2,
    parameter int unsigned     EDGE_TYPE   = 0,
    parameter int unsigned     IRQ_TYPE    = 1
) (
    input  logic             clk,
    input  logic             reset,
    pio_gen2_if.slave        bus,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] out_oe,
    output logic             irq
);

    typedef enum logic [2:0] {
        A_DATA = 3'd0,
        A_DIR  = 3'd1,
        A_MASK = 3'd2,
        A_CAP  = 3'd3,
        A_SET  = 3'd4,
        A_CLR  = 3'd5,
        A_RSV6 = 3'd6,
        A_RSV7 = 3'd7
    } reg_addr_t;

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic [31:0]      r_rdata;
    logic             r_irq;

    reg_addr_t        w_addr;
    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_in_sync;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_cap_clr;
    logic [WIDTH-1:0] w_dout_nxt;
    logic [WIDTH-1:0] w_irq_src;
    logic [31:0]      w_rdata;

    assign w_addr    = reg_addr_t'(bus.address);
    assign w_wr      = bus.chipselect & ~bus.write_n;
    assign w_wdata   = bus.writedata[WIDTH-1:0];
    assign w_in_sync = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_edge = '0;
        case (EDGE_TYPE)
            0:       w_edge = w_in_sync & ~r_prev;
            1:       w_edge = ~w_in_sync & r_prev;
            default: w_edge = w_in_sync ^ r_prev;
        endcase
    end

    assign w_cap_clr = (w_wr && w_addr == A_CAP) ? w_wdata : '0;
    assign w_irq_src = (IRQ_TYPE == 0) ? w_in_sync : r_cap;

    always_comb begin
        w_dout_nxt = r_dout;
        if (w_wr) begin
            case (w_addr)
                A_DATA:  w_dout_nxt = w_wdata;
                A_SET:   w_dout_nxt = r_dout | w_wdata;
                A_CLR:   w_dout_nxt = r_dout & ~w_wdata;
                default: w_dout_nxt = r_dout;
            endcase
        end
    end

    // Read mux sees current register state, so readdata lags address by one clock.
    always_comb begin
        w_rdata = '0;
        case (w_addr)
            A_DATA:  w_rdata[WIDTH-1:0] = (r_dir & r_dout) | (~r_dir & w_in_sync);
            A_DIR:   w_rdata[WIDTH-1:0] = r_dir;
            A_MASK:  w_rdata[WIDTH-1:0] = r_mask;
            A_CAP:   w_rdata[WIDTH-1:0] = r_cap;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= w_in_sync;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout  <= RESET_VALUE;
            r_dir   <= '0;
            r_mask  <= '0;
            r_cap   <= '0;
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_dout  <= w_dout_nxt;
            if (w_wr && w_addr == A_DIR)  r_dir  <= w_wdata;
            if (w_wr && w_addr == A_MASK) r_mask <= w_wdata;
            // A new edge overrides a simultaneous write-1-to-clear on the same bit.
            r_cap   <= (r_cap & ~w_cap_clr) | w_edge;
            r_rdata <= w_rdata;
            r_irq   <= |(r_mask & w_irq_src);
        end
    end

    assign bus.readdata = r_rdata;
    assign out_port     = r_dout;
    assign out_oe       = r_dir;
    assign irq          = r_irq;

endmodule

// File: tb/tb_pio_gen2.sv
// Directed-vector bench for pio_gen2 (default parameters: 32 bits, 2 sync
// stages, rising-edge capture, edge-sourced interrupt).
module tb_pio_gen2;
    logic        clk;
    logic        reset;
    logic [31:0] in_port;
    logic [31:0] out_port;
    logic [31:0] out_oe;
    logic        irq;
    logic [31:0] rd;
    int unsigned n_vec;
    int unsigned n_err;

    pio_gen2_if bus ();

    pio_gen2 #(
        .WIDTH(32), .RESET_VALUE(32'h0), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(1)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .in_port(in_port),
        .out_port(out_port), .out_oe(out_oe), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
        @(negedge clk);
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        in_port = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state and all eight addresses
        check_vec("rst_out_port", out_port, 32'h0);
        check_vec("rst_out_oe", out_oe, 32'h0);
        check_vec("rst_irq", {31'b0, irq}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i), rd);
            check_vec($sformatf("rst_read_a%0d", i), rd, 32'h0);
        end

        // Mixed direction read-back
        bus_write(3'd1, 32'h0000FFFF);
        bus_write(3'd0, 32'h12345678);
        in_port = 32'hABCD0000;
        repeat (4) @(negedge clk);
        check_vec("mix_out_port", out_port, 32'h12345678);
        check_vec("mix_out_oe", out_oe, 32'h0000FFFF);
        bus_read(3'd0, rd);
        check_vec("mix_data_read", rd, 32'hABCD5678);
        bus_read(3'd3, rd);
        check_vec("mix_cap_rising", rd, 32'hABCD0000);
        bus_write(3'd3, 32'hFFFFFFFF);
        bus_read(3'd3, rd);
        check_vec("mix_cap_cleared", rd, 32'h0);
        check_vec("mix_irq_masked", {31'b0, irq}, 32'h0);

        // Atomic set / clear
        bus_write(3'd0, 32'h00000001);
        bus_write(3'd4, 32'h000000F0);
        bus_write(3'd5, 32'h00000018);
        check_vec("setclr_out_port", out_port, 32'h000000E1);
        bus_read(3'd0, rd);
        check_vec("setclr_data_read", rd, 32'hABCD00E1);
        bus_read(3'd4, rd);
        check_vec("outset_reads0", rd, 32'h0);
        bus_read(3'd5, rd);
        check_vec("outclr_reads0", rd, 32'h0);
        bus_write(3'd2, 32'h12340000);
        bus_read(3'd2, rd);
        check_vec("mask_readback", rd, 32'h12340000);
        bus_write(3'd6, 32'hFFFFFFFF);
        bus_read(3'd6, rd);
        check_vec("rsv6_reads0", rd, 32'h0);
        check_vec("rsv_write_ignored", out_port, 32'h000000E1);

        // Edge capture latency and interrupt
        in_port = '0;
        repeat (4) @(negedge clk);
        bus_write(3'd3, 32'hFFFFFFFF);
        bus_write(3'd2, 32'h00000001);
        @(negedge clk);
        in_port[0] = 1'b1; bus.address = 3'd3;
        repeat (3) @(negedge clk);
        check_vec("edge_cap_before", bus.readdata, 32'h0);
        check_vec("edge_irq_before", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check_vec("edge_cap_at3", bus.readdata, 32'h1);
        check_vec("edge_irq_at4", {31'b0, irq}, 32'h1);
        bus_write(3'd3, 32'h00000001);
        check_vec("clr_irq_still1", {31'b0, irq}, 32'h1);
        @(negedge clk);
        check_vec("clr_irq_drops", {31'b0, irq}, 32'h0);
        bus_read(3'd3, rd);
        check_vec("clr_cap_zero", rd, 32'h0);

        // Set wins over simultaneous clear on bit 3
        @(negedge clk);
        in_port[3] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.address = 3'd3; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = 32'h8;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        bus_read(3'd3, rd);
        check_vec("setwins_cap", rd, 32'h00000008);

        // Reset mid-operation
        bus_write(3'd2, 32'h00000008);
        bus_write(3'd0, 32'h000000FF);
        @(negedge clk);
        check_vec("pre_rst_irq", {31'b0, irq}, 32'h1);
        check_vec("pre_rst_out", out_port, 32'h000000FF);
        bus.address = 3'd3;
        #2 reset = 1'b1;
        #1;
        check_vec("midrst_irq", {31'b0, irq}, 32'h0);
        check_vec("midrst_out", out_port, 32'h0);
        check_vec("midrst_rdata", bus.readdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        in_port = '0;
        bus_read(3'd3, rd);
        check_vec("midrst_cap", rd, 32'h0);
        bus_read(3'd2, rd);
        check_vec("midrst_mask", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pio_gen2.md
Name: pio_gen2

Overview:
- Parametrised successor to the single-register PIO: Avalon-MM slave giving HPS software a WIDTH-bit general-purpose port.
- Adds per-bit direction control and atomic set/clear of outputs.
- Adds synchronised inputs, edge capture and a maskable interrupt.
- Sits on the lightweight HPS-to-FPGA bridge in soc_system, alongside existing PIO instances.

Parameters:
- WIDTH, 32, port width in bits; legal range 1..32.
- RESET_VALUE, 0, reset value of the output data register (WIDTH bits).
- SYNC_STAGES, 2, number of input synchroniser flops; legal range 2..4.
- EDGE_TYPE, 0, edge that sets a capture bit: 0 = rising, 1 = falling, 2 = any.
- IRQ_TYPE, 1, interrupt source: 0 = level (synced input), 1 = edge (capture register).

Ports:
- clk  in  1  system clock; the block's only clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  register word select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; qualified by chipselect.
- writedata  in  32  write data; bits >= WIDTH ignored.
- readdata  out  32  registered read data; bits >= WIDTH read 0.
- in_port  in  WIDTH  asynchronous external inputs.
- out_port  out  WIDTH  output data register.
- out_oe  out  WIDTH  per-bit output enable (= direction register).
- irq  out  1  registered interrupt request, active-high.

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-high. All flops clear on reset assertion, independent of clk.
- Reset values:
  - data_out = RESET_VALUE; direction = 0 (all inputs); irq_mask = 0; edge_capture = 0.
  - Synchroniser and previous-value flops = 0; readdata = 0; irq = 0.
- Register map (word address). A write occurs when chipselect && !write_n.
  - 0 DATA. Read: (direction & data_out) | (~direction & in_sync). Write: data_out <= writedata.
  - 1 DIRECTION. R/W; 1 = output.
  - 2 IRQ_MASK. R/W.
  - 3 EDGE_CAPTURE. Read: capture bits. Write: each 1 clears that bit; 0 leaves it unchanged.
  - 4 OUTSET. Write: data_out <= data_out | writedata. Reads 0.
  - 5 OUTCLEAR. Write: data_out <= data_out & ~writedata. Reads 0.
  - 6, 7: reserved; read 0, writes ignored.
- Read timing:
  - readdata updates every clock from address, regardless of chipselect; 1-cycle read latency, no wait states.
  - A write to DATA and a read of DATA in consecutive cycles return the new value.
- Input path:
  - in_port passes through a SYNC_STAGES-flop chain to produce in_sync.
  - in_prev is in_sync delayed one cycle.
- Edge detection:
  - EDGE_TYPE 0: in_sync & ~in_prev.
  - EDGE_TYPE 1: ~in_sync & in_prev.
  - EDGE_TYPE 2: in_sync ^ in_prev.
  - Latency from an in_port change to the edge_capture set = SYNC_STAGES + 1 clocks.
- Edge capture: bits are sticky until cleared by software. If a detected edge and a write-1-to-clear hit the same bit in the same cycle, set wins and the bit stays 1.
- Interrupt:
  - irq is registered: irq <= |(irq_mask & src), where src = edge_capture (IRQ_TYPE 1) or in_sync (IRQ_TYPE 0).
  - irq follows its source one cycle later; clearing the capture bit or the mask deasserts irq one cycle after the register update.
- Output enable: out_oe = direction; out_port = data_out, driven regardless of direction. The top level builds the tristate.
- Reset mid-operation: a pending capture, irq, or in-flight readdata is discarded; all outputs take reset values immediately.

Test Plan:
- Reset, then read addr 0..7 with in_port = 0 → all reads 0; out_port = RESET_VALUE; out_oe = 0; irq = 0.
- Write DIRECTION = 0x0000FFFF, DATA = 0x12345678; in_port = 0xABCD0000 → out_port = 0x12345678; DATA read = 0xABCD5678.
- Write OUTSET 0x000000F0, then OUTCLEAR 0x00000018 starting from DATA 0x00000001 → out_port = 0x000000E1; reads of addr 4/5 = 0.
- EDGE_TYPE 0, IRQ_TYPE 1: mask = 0x1; pulse in_port[0] 0→1 → capture = 0x1 at SYNC_STAGES+1 cycles; irq = 1 one cycle later. Write 0x1 to addr 3 → capture 0, irq 0 next cycle.
- Rising edge on bit 3 in the same cycle as a write of 0x8 to EDGE_CAPTURE → bit 3 remains 1.
- Assert reset while irq = 1 and data_out = 0xFF → irq, out_port and capture = 0 before the next clk edge.
